uart_trans: RTL and testbench



---
 rtl/uart_trans_if.sv | 7 +
 rtl/uart_trans.sv | 76 +++++++
 tb/tb_uart_trans.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_trans_if.sv
// uart_trans_if: serial-side signals of the UART transmitter (enable switch in, TX line out)
interface uart_trans_if;
  logic SW1;
  logic UART_RXD_OUT;
  modport master (output SW1, input UART_RXD_OUT);
  modport slave (input SW1, output UART_RXD_OUT);
endinterface

// File: rtl/uart_trans.sv
// uart_trans: repeats a fixed 8N1 LSB-first message on the UART TX pin while SW1 is on
module uart_trans #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int MSG_LEN = 14
) (
  input logic CLK100MHZ,
  input logic SW0,
  uart_trans_if.slave u
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [111:0] MSG = {8'h0A, 8'h0D, 8'h21, 8'h64, 8'h6C, 8'h72, 8'h6F,
                                  8'h57, 8'h20, 8'h6F, 8'h6C, 8'h6C, 8'h65, 8'h48};
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [1:0] r_sync;
  logic [1:0] r_state;
  logic [BW-1:0] r_cnt;
  logic [2:0] r_bit;
  logic [IW-1:0] r_idx;
  logic [7:0] r_shift;
  logic r_tx;
  logic w_sw;
  logic w_term;
  logic [IW-1:0] w_idx_nxt;
  logic [7:0] w_cur;
  logic [7:0] w_nxt;
  always_comb begin
    w_sw = r_sync[1];
    w_term = r_cnt == BW'(CLKS_PER_BIT - 1);
    w_idx_nxt = (r_idx == IW'(MSG_LEN - 1)) ? '0 : r_idx + 1'b1;
    w_cur = MSG[{r_idx, 3'b000} +: 8];
    w_nxt = MSG[{w_idx_nxt, 3'b000} +: 8];
  end
  assign u.UART_RXD_OUT = r_tx;
  // r_tx is loaded with the level of the state being entered, so the line is glitch-free
  always_ff @(posedge CLK100MHZ) begin
    if (SW0) begin
      r_sync <= '0;
      r_state <= IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_idx <= '0;
      r_shift <= '0;
      r_tx <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], u.SW1};
      r_cnt <= (r_state == IDLE || w_term) ? '0 : r_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          r_tx <= !w_sw;
          if (w_sw) begin
            r_shift <= w_cur;
            r_state <= START;
          end
        end
        START: if (w_term) begin
          r_state <= DATA;
          r_bit <= '0;
          r_tx <= r_shift[0];
        end
        DATA: if (w_term) begin
          r_shift <= r_shift >> 1;
          r_bit <= r_bit + 1'b1;
          r_state <= (r_bit == 3'd7) ? STOP : DATA;
          r_tx <= (r_bit == 3'd7) ? 1'b1 : r_shift[1];
        end
        default: if (w_term) begin
          r_idx <= w_idx_nxt;
          r_state <= w_sw ? START : IDLE;
          r_tx <= !w_sw;
          if (w_sw) r_shift <= w_nxt;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_trans.sv
// tb_uart_trans: directed stimulus with a byte scoreboard fed by a line-level frame decoder
module tb_uart_trans;
  logic clk = 1'b0;
  logic sw0 = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] rom [14] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                           8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};
  logic [7:0] sb [$];
  uart_trans_if u ();
  uart_trans #(.CLKS_PER_BIT(4), .MSG_LEN(14)) dut (.CLK100MHZ(clk), .SW0(sw0), .u(u));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic line_bit(input logic [7:0] b, input int j);
    int s = j / 4;
    return (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : b[s-1];
  endfunction
  // frame decoder: k counts negedges since the first low sample of the start bit
  initial begin
    logic busy = 1'b0;
    int k = 0;
    logic [7:0] b = '0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (sw0) busy = 1'b0;
      else if (!busy) begin
        if (u.UART_RXD_OUT === 1'b0) begin
          busy = 1'b1;
          k = 0;
        end
      end else begin
        k++;
        if (k >= 6 && k <= 34 && (k - 6) % 4 == 0) b[3'((k - 6) / 4)] = u.UART_RXD_OUT;
        if (k == 38) begin
          busy = 1'b0;
          chk("sb_nonempty", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rx_byte", 32'(b), 32'(e));
          end
          chk("stop_bit", 32'(u.UART_RXD_OUT), 1);
        end
      end
    end
  end
  initial begin
    logic ok;
    u.SW1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (i > 0) chk("rst_line", 32'(u.UART_RXD_OUT), 1);
    end
    u.SW1 = 1'b1;
    step(10);
    chk("rst_wins", 32'(u.UART_RXD_OUT), 1);
    u.SW1 = 1'b0;
    step(1);
    sw0 = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (u.UART_RXD_OUT !== 1'b1) ok = 1'b0;
    end
    chk("idle_1000", 32'(ok), 1);
    for (int f = 0; f < 17; f++) sb.push_back(rom[f % 14]);
    u.SW1 = 1'b1;
    step(1);
    chk("sync_lat1", 32'(u.UART_RXD_OUT), 1);
    step(1);
    chk("sync_lat2", 32'(u.UART_RXD_OUT), 1);
    for (int j = 0; j < 40; j++) begin
      step(1);
      chk($sformatf("frame0_s%0d", j), 32'(u.UART_RXD_OUT), 32'(line_bit(8'h48, j)));
    end
    step(1);
    chk("b2b_start", 32'(u.UART_RXD_OUT), 0);
    step(617);
    u.SW1 = 1'b0;
    step(22);
    chk("drop_stop", 32'(u.UART_RXD_OUT), 1);
    ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (u.UART_RXD_OUT !== 1'b1) ok = 1'b0;
    end
    chk("drop_idle", 32'(ok), 1);
    chk("sb_drained1", 32'(sb.size()), 0);
    sb.push_back(8'h6C);
    u.SW1 = 1'b1;
    step(2);
    chk("resume_hi", 32'(u.UART_RXD_OUT), 1);
    step(1);
    chk("resume_start", 32'(u.UART_RXD_OUT), 0);
    step(40);
    sb.push_back(8'h48);
    step(9);
    sw0 = 1'b1;
    step(1);
    chk("rst_mid", 32'(u.UART_RXD_OUT), 1);
    step(1);
    sw0 = 1'b0;
    step(2);
    chk("restart_hi", 32'(u.UART_RXD_OUT), 1);
    step(1);
    chk("restart_start", 32'(u.UART_RXD_OUT), 0);
    u.SW1 = 1'b0;
    for (int i = 0; i < 200 && sb.size() > 0; i++) step(1);
    step(5);
    chk("sb_drained2", 32'(sb.size()), 0);
    chk("final_idle", 32'(u.UART_RXD_OUT), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
